// File: rtl/rect_flip_if.sv
// rect_flip_if: handshake/bus bundle for the rectangle-flip sequencer.
//   master modport (sequencer side):
//     in : start, m_in[N], out_ready
//     out: busy, out_valid, m_out[N], r1, r2 [RW], c1, c2 [CW], flips[KW], done
//   slave modport (search control / consumer side): directions mirrored.
interface rect_flip_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int N     = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NRECT = ((ROWS * (ROWS - 1)) / 2) * ((COLS * (COLS - 1)) / 2);
    localparam int KW    = $clog2(NRECT + 1);

    logic          start;
    logic [N-1:0]  m_in;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  m_out;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
    logic [KW-1:0] flips;
    logic          done;

    modport master (
        input  start, m_in, out_ready,
        output busy, out_valid, m_out, r1, r2, c1, c2, flips, done
    );

    modport slave (
        output start, m_in, out_ready,
        input  busy, out_valid, m_out, r1, r2, c1, c2, flips, done
    );
endinterface

// File: rtl/rect_flip_sched.sv
// rect_flip_sched: latches a base matrix, walks every axis-aligned rectangle
// (r1<r2, c1<c2) with r1 outermost and c2 innermost, and for every rectangle
// whose corners form a checkerboard emits base XOR corner-mask on a
// valid/ready stream. All outputs are registered.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : rect_flip_if.master (start/m_in in, stream + status out)
// Cell (r,c) lives at bit N-1-(c*ROWS+r): column-major, MSB first.
module rect_flip_sched #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    rect_flip_if.master  bus
);
    localparam int N     = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NRECT = ((ROWS * (ROWS - 1)) / 2) * ((COLS * (COLS - 1)) / 2);
    localparam int KW    = $clog2(NRECT + 1);
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit position of cell (r,c) in the flattened matrix.
    function automatic logic [IW-1:0] bit_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        bit_idx = IW'(N - 1 - (int'(c) * ROWS + int'(r)));
    endfunction

    state_t        state_r, state_s;
    logic [N-1:0]  base_r, base_s;
    // Rectangle currently under evaluation (separate from the emitted copy).
    logic [RW-1:0] cr1_r, cr2_r, cr1_s, cr2_s;
    logic [CW-1:0] cc1_r, cc2_r, cc1_s, cc2_s;
    // Registered outputs.
    logic [N-1:0]  m_out_r, m_out_s;
    logic [RW-1:0] or1_r, or2_r, or1_s, or2_s;
    logic [CW-1:0] oc1_r, oc2_r, oc1_s, oc2_s;
    logic [KW-1:0] flips_r, flips_s;
    logic          busy_r, busy_s;
    logic          out_valid_r, out_valid_s;
    logic          done_r, done_s;

    // Rectangle following the current one in enumeration order.
    logic [RW-1:0] adv_r1_s, adv_r2_s;
    logic [CW-1:0] adv_c1_s, adv_c2_s;
    logic          last_s;
    logic          corner_a_s, corner_b_s, corner_c_s, corner_d_s;
    logic          rect_ok_s;
    logic [N-1:0]  mask_s;

    assign corner_a_s = base_r[bit_idx(cr1_r, cc1_r)];
    assign corner_b_s = base_r[bit_idx(cr1_r, cc2_r)];
    assign corner_c_s = base_r[bit_idx(cr2_r, cc1_r)];
    assign corner_d_s = base_r[bit_idx(cr2_r, cc2_r)];
    assign rect_ok_s  = (corner_a_s == corner_d_s) && (corner_b_s == corner_c_s)
                        && (corner_a_s != corner_b_s);

    assign last_s = (cr1_r == RW'(ROWS - 2)) && (cr2_r == RW'(ROWS - 1))
                    && (cc1_r == CW'(COLS - 2)) && (cc2_r == CW'(COLS - 1));

    // Corner mask of the rectangle under evaluation.
    always_comb begin
        mask_s = {N{1'b0}};
        mask_s[bit_idx(cr1_r, cc1_r)] = 1'b1;
        mask_s[bit_idx(cr1_r, cc2_r)] = 1'b1;
        mask_s[bit_idx(cr2_r, cc1_r)] = 1'b1;
        mask_s[bit_idx(cr2_r, cc2_r)] = 1'b1;
    end

    // Enumeration step: bump c2, then c1, then r2, then r1; inner indices restart.
    always_comb begin
        adv_r1_s = cr1_r;
        adv_r2_s = cr2_r;
        adv_c1_s = cc1_r;
        adv_c2_s = cc2_r;
        if (cc2_r != CW'(COLS - 1)) begin
            adv_c2_s = cc2_r + CW'(1);
        end else if (cc1_r != CW'(COLS - 2)) begin
            adv_c1_s = cc1_r + CW'(1);
            adv_c2_s = cc1_r + CW'(2);
        end else if (cr2_r != RW'(ROWS - 1)) begin
            adv_r2_s = cr2_r + RW'(1);
            adv_c1_s = CW'(0);
            adv_c2_s = CW'(1);
        end else begin
            adv_r1_s = cr1_r + RW'(1);
            adv_r2_s = cr1_r + RW'(2);
            adv_c1_s = CW'(0);
            adv_c2_s = CW'(1);
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead.
    always_comb begin
        state_s     = state_r;
        base_s      = base_r;
        cr1_s       = cr1_r;
        cr2_s       = cr2_r;
        cc1_s       = cc1_r;
        cc2_s       = cc2_r;
        m_out_s     = m_out_r;
        or1_s       = or1_r;
        or2_s       = or2_r;
        oc1_s       = oc1_r;
        oc2_s       = oc2_r;
        flips_s     = flips_r;
        busy_s      = busy_r;
        out_valid_s = out_valid_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    base_s      = bus.m_in;
                    flips_s     = {KW{1'b0}};
                    cr1_s       = RW'(0);
                    cr2_s       = RW'(1);
                    cc1_s       = CW'(0);
                    cc2_s       = CW'(1);
                    busy_s      = 1'b1;
                    out_valid_s = 1'b0;
                    state_s     = ST_SCAN;
                end else begin
                    busy_s      = 1'b0;
                    out_valid_s = 1'b0;
                end
            end
            ST_SCAN: begin
                if (rect_ok_s) begin
                    m_out_s     = base_r ^ mask_s;
                    or1_s       = cr1_r;
                    or2_s       = cr2_r;
                    oc1_s       = cc1_r;
                    oc2_s       = cc2_r;
                    out_valid_s = 1'b1;
                    state_s     = ST_EMIT;
                end else if (last_s) begin
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    cr1_s = adv_r1_s;
                    cr2_s = adv_r2_s;
                    cc1_s = adv_c1_s;
                    cc2_s = adv_c2_s;
                end
            end
            ST_EMIT: begin
                if (bus.out_ready) begin
                    flips_s     = flips_r + KW'(1);
                    out_valid_s = 1'b0;
                    if (last_s) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        cr1_s   = adv_r1_s;
                        cr2_s   = adv_r2_s;
                        cc1_s   = adv_c1_s;
                        cc2_s   = adv_c2_s;
                        state_s = ST_SCAN;
                    end
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s      = 1'b0;
                out_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            base_r      <= {N{1'b0}};
            cr1_r       <= RW'(0);
            cr2_r       <= RW'(0);
            cc1_r       <= CW'(0);
            cc2_r       <= CW'(0);
            m_out_r     <= {N{1'b0}};
            or1_r       <= RW'(0);
            or2_r       <= RW'(0);
            oc1_r       <= CW'(0);
            oc2_r       <= CW'(0);
            flips_r     <= {KW{1'b0}};
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            base_r      <= base_s;
            cr1_r       <= cr1_s;
            cr2_r       <= cr2_s;
            cc1_r       <= cc1_s;
            cc2_r       <= cc2_s;
            m_out_r     <= m_out_s;
            or1_r       <= or1_s;
            or2_r       <= or2_s;
            oc1_r       <= oc1_s;
            oc2_r       <= oc2_s;
            flips_r     <= flips_s;
            busy_r      <= busy_s;
            out_valid_r <= out_valid_s;
            done_r      <= done_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.m_out     = m_out_r;
    assign bus.r1        = or1_r;
    assign bus.r2        = or2_r;
    assign bus.c1        = oc1_r;
    assign bus.c2        = oc2_r;
    assign bus.flips     = flips_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_rect_flip_sched.sv
// tb_rect_flip_sched: directed bench for rect_flip_sched (4x4 matrix).
// Cycle k means the cycle after start was sampled at edge 0; outputs are
// sampled on the falling edge inside that cycle.
module tb_rect_flip_sched;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rect_flip_if #(.ROWS(4), .COLS(4)) bus ();

    rect_flip_sched #(.ROWS(4), .COLS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] em_m[$];
    logic [7:0]  em_rc[$];
    logic [5:0]  em_fl[$];
    logic [15:0] exp_m[$];
    logic [7:0]  exp_rc[$];
    int first_valid, valid_cycles, busy_bad, stall_n, stall_bad, done_cyc;

    function automatic int bidx(input int r, input int c);
        return 15 - (c * 4 + r);
    endfunction

    function automatic logic [15:0] fmask(input int r1, input int r2, input int c1, input int c2);
        logic [15:0] m;
        m = 16'h0000;
        m = m | (16'h0001 << bidx(r1, c1));
        m = m | (16'h0001 << bidx(r1, c2));
        m = m | (16'h0001 << bidx(r2, c1));
        m = m | (16'h0001 << bidx(r2, c2));
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: start with base, out_ready low in cycles lo_a..lo_b, optional
    // extra start pulse (with a different m_in) in cycle restart.
    task automatic run(input logic [15:0] base, input int lo_a, input int lo_b, input int restart);
        logic        stall_prev;
        logic [15:0] pm;
        logic [7:0]  prc;
        logic [5:0]  pf;
        em_m.delete();
        em_rc.delete();
        em_fl.delete();
        first_valid = -1; valid_cycles = 0; busy_bad = 0;
        stall_n = 0; stall_bad = 0; done_cyc = -1;
        stall_prev = 1'b0; pm = 16'h0000; prc = 8'h00; pf = 6'h00;
        @(negedge clk);
        bus.m_in = base; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.start     = (k == restart);
            bus.m_in      = (k == restart) ? ~base : base;
            bus.out_ready = !((k >= lo_a) && (k <= lo_b));
            if (stall_prev) begin
                stall_n++;
                if (!bus.out_valid || (bus.m_out !== pm) || ({bus.r1, bus.r2, bus.c1, bus.c2} !== prc)
                    || (bus.flips !== pf))
                    stall_bad++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            pm  = bus.m_out;
            prc = {bus.r1, bus.r2, bus.c1, bus.c2};
            pf  = bus.flips;
            if (bus.done) begin
                done_cyc = k;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.out_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = k;
                if (bus.out_ready) begin
                    em_m.push_back(bus.m_out);
                    em_rc.push_back({bus.r1, bus.r2, bus.c1, bus.c2});
                    em_fl.push_back(bus.flips);
                end
            end
        end
        bus.start = 1'b0; bus.m_in = base; bus.out_ready = 1'b1;
    endtask

    task automatic check_after_done(input string tag, input int exp_flips);
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_flips_final"}, 32'(bus.flips), 32'(exp_flips));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Base 8400 produces exactly one emit on (0,1,0,1).
    task automatic check_single(input string tag, input int lo_a, input int lo_b,
                                input int exp_done, input int exp_vc, input int exp_stalls);
        run(16'h8400, lo_a, lo_b, -1);
        chk({tag, "_first_valid"}, 32'(first_valid), 32'd2);
        chk({tag, "_emits"}, 32'(em_m.size()), 32'd1);
        chk({tag, "_m_out"}, 32'((em_m.size() > 0) ? em_m[0] : 16'hxxxx), 32'h4800);
        chk({tag, "_rect"}, 32'((em_rc.size() > 0) ? em_rc[0] : 8'hxx), {24'd0, 2'd0, 2'd1, 2'd0, 2'd1});
        chk({tag, "_valid_cycles"}, 32'(valid_cycles), 32'(exp_vc));
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_stalls));
        chk({tag, "_stall_stable"}, 32'(stall_bad), 32'd0);
        chk({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        check_after_done(tag, 1);
    endtask

    // Checkerboard A5A5: compare emits against the odd-span rectangle list.
    task automatic check_checker(input string tag);
        chk({tag, "_emits"}, 32'(em_m.size()), 32'd16);
        chk({tag, "_first_m_out"}, 32'((em_m.size() > 0) ? em_m[0] : 16'hxxxx), 32'h69A5);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_m_out_", $sformatf("%0d", i)},
                32'((i < em_m.size()) ? em_m[i] : 16'hxxxx), 32'(exp_m[i]));
            chk({tag, "_rect_", $sformatf("%0d", i)},
                32'((i < em_rc.size()) ? em_rc[i] : 8'hxx), 32'(exp_rc[i]));
            chk({tag, "_flips_at_emit_", $sformatf("%0d", i)},
                32'((i < em_fl.size()) ? em_fl[i] : 6'hxx), 32'(i));
        end
        chk({tag, "_busy_run"}, 32'(busy_bad), 32'd0);
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd53);
        check_after_done(tag, 16);
    endtask

    initial begin
        int w;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.m_in = 16'h0000;
        bus.out_ready = 1'b1;

        for (int r1 = 0; r1 < 4; r1++)
            for (int r2 = r1 + 1; r2 < 4; r2++)
                for (int c1 = 0; c1 < 4; c1++)
                    for (int c2 = c1 + 1; c2 < 4; c2++)
                        if (((r2 - r1) % 2 == 1) && ((c2 - c1) % 2 == 1)) begin
                            exp_m.push_back(16'hA5A5 ^ fmask(r1, r2, c1, c2));
                            exp_rc.push_back({2'(r1), 2'(r2), 2'(c1), 2'(c2)});
                        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_m_out", 32'(bus.m_out), 32'd0);
        chk("rst_rect", 32'({bus.r1, bus.r2, bus.c1, bus.c2}), 32'd0);
        chk("rst_flips", 32'(bus.flips), 32'd0);
        rst = 1'b0;

        // All-zero matrix: nothing valid, 36 scan cycles
        run(16'h0000, 1000, 0, -1);
        chk("zero_emits", 32'(em_m.size()), 32'd0);
        chk("zero_valid_cycles", 32'(valid_cycles), 32'd0);
        chk("zero_busy_run", 32'(busy_bad), 32'd0);
        chk("zero_done_cycle", 32'(done_cyc), 32'd37);
        check_after_done("zero", 0);

        // Single valid rectangle, out_ready high
        check_single("single", 1000, 0, 38, 1, 0);

        // Checkerboard, 16 emits; flips holds in IDLE afterwards
        run(16'hA5A5, 1000, 0, -1);
        check_checker("chk");
        repeat (3) @(negedge clk);
        chk("chk_flips_hold_idle", 32'(bus.flips), 32'd16);

        // Backpressure: ready low in cycles 2..6
        check_single("bp", 2, 6, 43, 6, 5);

        // Extra start in cycle 10 is ignored
        run(16'hA5A5, 1000, 0, 10);
        check_checker("restart");

        // Reset during EMIT, then a clean rerun
        @(negedge clk);
        bus.m_in = 16'hA5A5; bus.start = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        w = 0;
        while (!bus.out_valid && (w < 20)) begin
            @(negedge clk);
            w++;
        end
        chk("rst_mid_reached_emit", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_m_out", 32'(bus.m_out), 32'd0);
        chk("rst_mid_rect", 32'({bus.r1, bus.r2, bus.c1, bus.c2}), 32'd0);
        chk("rst_mid_flips", 32'(bus.flips), 32'd0);
        @(negedge clk);
        chk("rst_mid_idle_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_no_done", 32'(bus.done), 32'd0);
        check_single("after_rst", 1000, 0, 38, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
